// File: rtl/rand_share_arbiter.sv
// -----------------------------------------------------------------------------
// rand_share_arbiter
//
// Shares a single 49-bit LFSR random source among N_REQ requesters using
// round-robin arbitration. At most one random word is issued per clock. The
// LFSR advances only when a word is issued, so for a given request pattern
// the sequence of words is fully deterministic. After reset, and after every
// seed load, the LFSR is advanced WARMUP_CYCLES times before any request is
// served.
//
// Ports:
//   clk        in   1             clock
//   rst        in   1             asynchronous active-high reset
//   req        in   N_REQ         level-sensitive per-requester requests
//   gnt        out  N_REQ         registered one-hot grant, zero when idle
//   rnd_out    out  RET_INT_SIZE  random word, valid while rnd_valid is high
//   rnd_valid  out  1             one-cycle strobe coincident with gnt
//   busy       out  1             high during warm-up; requests are ignored
//   seed_load  in   1             synchronous seed-load strobe
//   seed_in    in   49            seed value (all-ones replaced by SEED)
//   issue_cnt  out  32            words issued since reset / seed load, wraps
// -----------------------------------------------------------------------------
module rand_share_arbiter #(
    parameter int          N_REQ         = 4,
    parameter int          RET_INT_SIZE  = 20,
    parameter logic [48:0] SEED          = 49'd1234567890,
    parameter int          WARMUP_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        gnt,
    output logic [RET_INT_SIZE-1:0] rnd_out,
    output logic                    rnd_valid,
    output logic                    busy,
    input  logic                    seed_load,
    input  logic [48:0]             seed_in,
    output logic [31:0]             issue_cnt
);

    localparam int          PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [48:0] ALL_ONES = '1;

    typedef enum logic {
        WARMUP = 1'b0,
        SERVE  = 1'b1
    } state_t;

    // XNOR feedback: the all-ones state is the only lock-up state.
    function automatic logic [48:0] lfsr_next(input logic [48:0] st);
        return {st[47:0], ~(st[48] ^ st[39])};
    endfunction

    state_t             fsm;
    logic [48:0]        s;
    logic [48:0]        nxt;
    logic [15:0]        warm_cnt;
    logic [PTR_W-1:0]   ptr;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    int                 cand_i;

    assign nxt = lfsr_next(s);

    // Circular priority search starting at ptr; the first active request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_i    = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_i = int'(ptr) + k;
            if (cand_i >= N_REQ) begin
                cand_i = cand_i - N_REQ;
            end
            cand = PTR_W'(cand_i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= SEED;
            fsm       <= WARMUP;
            warm_cnt  <= '0;
            ptr       <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_out   <= '0;
            issue_cnt <= '0;
            busy      <= 1'b1;
        end else if (seed_load) begin
            // A seed load overrides everything, including a pending grant.
            s         <= (seed_in == ALL_ONES) ? SEED : seed_in;
            fsm       <= WARMUP;
            warm_cnt  <= '0;
            ptr       <= '0;
            issue_cnt <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (fsm)
                WARMUP: begin
                    gnt       <= '0;
                    rnd_valid <= 1'b0;
                    if (WARMUP_CYCLES == 0) begin
                        fsm  <= SERVE;
                        busy <= 1'b0;
                    end else begin
                        s        <= nxt;
                        warm_cnt <= warm_cnt + 16'd1;
                        // Leave on the edge that performs the last advance.
                        if (({1'b0, warm_cnt} + 17'd1) == 17'(WARMUP_CYCLES)) begin
                            fsm  <= SERVE;
                            busy <= 1'b0;
                        end
                    end
                end
                SERVE: begin
                    if (win_found) begin
                        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        rnd_out   <= nxt[RET_INT_SIZE-1:0];
                        rnd_valid <= 1'b1;
                        s         <= nxt;
                        ptr       <= (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
                        issue_cnt <= issue_cnt + 32'd1;
                    end else begin
                        gnt       <= '0;
                        rnd_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm <= WARMUP;
                end
            endcase
        end
    end

endmodule
